// File: rtl/csr_issue_scheduler_pkg.sv
// Shared types for the CSR issue scheduler.
// Pack layouts are shared with dispatch, execute and commit.
package csr_issue_scheduler_pkg;

  localparam int ROB_ID_WIDTH = 6;
  localparam int PHY_ID_WIDTH = 7;
  localparam int XLEN = 32;
  localparam int CSR_SCHED_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HEAD,
    HOLD
  } csr_sched_state_t;

  typedef struct packed {
    logic                    enable;
    logic [ROB_ID_WIDTH-1:0] rob_id;
    logic [2:0]              op;
    logic [11:0]             csr_addr;
    logic                    rs1_need_map;
    logic [PHY_ID_WIDTH-1:0] rs1_phy;
    logic [XLEN-1:0]         src1_value;
    logic                    src1_loaded;
    logic                    rd_need_map;
    logic [PHY_ID_WIDTH-1:0] rd_phy;
  } issue_execute_pack_t;

  typedef struct packed {
    logic                    enable;
    logic [PHY_ID_WIDTH-1:0] phy_id;
    logic [XLEN-1:0]         value;
  } execute_feedback_channel_t;

  typedef struct packed {
    logic enable;
    logic flush;
  } commit_feedback_pack_t;

  function automatic logic operand_ready(
    input issue_execute_pack_t p
  );
    return !p.rs1_need_map || p.src1_loaded;
  endfunction

endpackage

// File: rtl/csr_operand_wakeup.sv
// Captures a pending rs1 operand from the execute feedback channels.
// Lowest-index matching channel wins.
module csr_operand_wakeup
  import csr_issue_scheduler_pkg::*;
#(
  parameter int WAKEUP_PORTS = 4
) (
  input  issue_execute_pack_t       src,
  input  execute_feedback_channel_t wakeup_pack [WAKEUP_PORTS],
  output issue_execute_pack_t       dst
);

  logic hit;

  always_comb begin
    dst = src;
    hit = 1'b0;
    for (int i = 0; i < WAKEUP_PORTS; i++) begin
      if (!hit && src.rs1_need_map && !src.src1_loaded &&
          wakeup_pack[i].enable &&
          wakeup_pack[i].phy_id == src.rs1_phy) begin
        hit             = 1'b1;
        dst.src1_value  = wakeup_pack[i].value;
        dst.src1_loaded = 1'b1;
      end
    end
  end

endmodule

// File: rtl/csr_issue_scheduler.sv
// Serializing CSR scheduler: releases one op at the ROB head,
// then holds until it retires so CSR accesses are never speculative.
module csr_issue_scheduler
  import csr_issue_scheduler_pkg::*;
#(
  parameter int DEPTH        = CSR_SCHED_DEPTH,
  parameter int WAKEUP_PORTS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  issue_execute_pack_t       csr_sched_in_data,
  input  logic                      csr_sched_in_valid,
  output logic                      csr_sched_in_ready,
  input  execute_feedback_channel_t wakeup_pack [WAKEUP_PORTS],
  input  logic                      rob_head_valid,
  input  logic [ROB_ID_WIDTH-1:0]   rob_head_id,
  input  logic                      issue_csr_fifo_full,
  output issue_execute_pack_t       csr_issue_fifo_data_in,
  output logic                      csr_issue_fifo_push,
  input  commit_feedback_pack_t     commit_feedback_pack,
  output logic                      csr_sched_busy
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]             wptr_q;
  logic [AW:0]             rptr_q;
  csr_sched_state_t        state_q;
  csr_sched_state_t        state_d;
  logic [ROB_ID_WIDTH-1:0] held_q;

  issue_execute_pack_t ent_q [DEPTH];
  issue_execute_pack_t woken [DEPTH];
  issue_execute_pack_t enq_pack;
  issue_execute_pack_t head;

  logic empty;
  logic full;
  logic flush;
  logic enq;
  logic issue;
  logic head_retired;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    csr_operand_wakeup #(
      .WAKEUP_PORTS(WAKEUP_PORTS)
    ) u_wake (
      .src        (ent_q[g]),
      .wakeup_pack(wakeup_pack),
      .dst        (woken[g])
    );
  end

  csr_operand_wakeup #(
    .WAKEUP_PORTS(WAKEUP_PORTS)
  ) u_enq_wake (
    .src        (csr_sched_in_data),
    .wakeup_pack(wakeup_pack),
    .dst        (enq_pack)
  );

  assign empty = wptr_q == rptr_q;
  assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                 (wptr_q[AW] != rptr_q[AW]);
  assign flush = commit_feedback_pack.enable &&
                 commit_feedback_pack.flush;

  assign csr_sched_in_ready = !full && rst;
  assign enq = csr_sched_in_valid && csr_sched_in_ready && !flush;

  assign head = woken[rptr_q[AW-1:0]];

  assign issue = rst && !flush &&
                 state_q == WAIT_HEAD && !empty &&
                 operand_ready(head) &&
                 rob_head_valid &&
                 rob_head_id == head.rob_id &&
                 !issue_csr_fifo_full;

  assign head_retired = rob_head_valid && rob_head_id != held_q;

  assign csr_issue_fifo_push    = issue;
  assign csr_issue_fifo_data_in = rst ? head : '0;
  assign csr_sched_busy         = !empty || state_q == HOLD;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (enq) state_d = WAIT_HEAD;
      end
      WAIT_HEAD: begin
        if (issue) state_d = HOLD;
        else if (empty && !enq) state_d = IDLE;
      end
      HOLD: begin
        if (head_retired)
          state_d = (!empty || enq) ? WAIT_HEAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      state_q <= IDLE;
      held_q  <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (enq)   wptr_q <= wptr_q + 1'b1;
        if (issue) rptr_q <= rptr_q + 1'b1;
      end
      if (issue) held_q <= head.rob_id;
    end
  end

  // Payload needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) ent_q[i] <= woken[i];
    if (enq) ent_q[wptr_q[AW-1:0]] <= enq_pack;
  end

endmodule

// File: doc/csr_issue_scheduler.md
# csr_issue_scheduler

Serializing scheduler in front of the CSR execute unit. Buffers renamed CSR micro-ops from dispatch and captures pending rs1 operands from the execute feedback channels. Releases exactly one CSR op into the issue→CSR FIFO, and only once that op is the ROB head. Blocks further CSR issue until the released op has retired or a commit flush occurs, so CSR reads and writes are never speculative.

## Interface
- DEPTH, default 4: buffer entries; power of two, ≥2.
- WAKEUP_PORTS, default 4: number of execute feedback channels snooped.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- csr_sched_in_data  in  issue_execute_pack_t  CSR op from dispatch.
- csr_sched_in_valid  in  1  dispatch offers an op.
- csr_sched_in_ready  out  1  buffer can accept; transfer when valid && ready.
- wakeup_pack[WAKEUP_PORTS]  in  execute_feedback_channel_t  enable / phy_id / value broadcasts.
- rob_head_valid  in  1  ROB head entry exists.
- rob_head_id  in  `ROB_ID_WIDTH  ROB id at head.
- issue_csr_fifo_full  in  1  downstream FIFO full.
- csr_issue_fifo_data_in  out  issue_execute_pack_t  op released to the CSR unit.
- csr_issue_fifo_push  out  1  release strobe.
- commit_feedback_pack  in  commit_feedback_pack_t  flush when enable && flush.
- csr_sched_busy  out  1  buffer non-empty or state HOLD.

## Operation
- Circular buffer: DEPTH entries, wptr/rptr of log2(DEPTH)+1 bits. Empty when the pointers are equal. Full when indices are equal and wrap bits differ.
- Enqueue stores the pack unchanged, with one exception: if an enabled wakeup in the same cycle matches rs1_phy, the stored src1_value and src1_loaded already reflect that wakeup.
- Operand ready condition per entry: !rs1_need_map || src1_loaded.
- Wakeup applies every cycle to all valid entries with rs1_need_map && !src1_loaded && enable && phy_id == rs1_phy: src1_value ← value, src1_loaded ← 1. If several ports match, the lowest port index wins.
- FSM states:
  - IDLE: buffer empty. Enqueue → WAIT_HEAD.
  - WAIT_HEAD: head entry present. Issue when head is operand-ready && rob_head_valid && rob_head_id == head.rob_id && !issue_csr_fifo_full && !flush. On issue → HOLD, and held_rob_id ← head.rob_id.
  - HOLD: wait for retirement. Exit when rob_head_valid && rob_head_id != held_rob_id, to WAIT_HEAD if non-empty (including a same-cycle enqueue), else IDLE. HOLD never issues.
- Issue action: csr_issue_fifo_push = 1, and csr_issue_fifo_data_in = head entry with the current-cycle wakeup forwarded. The head is popped in the same cycle.
- Commit flush (commit_feedback_pack.enable && .flush):
  - Clears the buffer (wptr = rptr = 0) and drops any same-cycle enqueue.
  - Forces push = 0 and next state IDLE.
  - Has priority over every other event.
- Enqueue and issue-pop in the same cycle: both occur, and occupancy is unchanged.
- Illegal CSR address checks are not performed here; the CSR execute unit raises those exceptions.

## Timing
- csr_sched_in_ready = !full && rst; combinational from registered pointers, independent of csr_sched_in_valid. Full-and-popping does not raise ready in the same cycle.
- Release latency, with operand ready and the op already ROB head on entry: enqueue at cycle N → push at cycle N+1.
- A wakeup arriving in cycle N can enable issue in cycle N (forwarded); rob_head_id is sampled combinationally.
- HOLD exit is visible one cycle after the ROB head advances; back-to-back CSR ops are therefore ≥2 cycles apart.
- Reset (rst low at a clk edge):
  - Pointers 0, state IDLE, held_rob_id 0.
  - push 0, data_in all-zero, busy 0, in_ready 0 while rst is low.
  - Reset mid-HOLD discards everything, with no push.
- All outputs except in_ready and push/data_in are derived from registered state only.

## Structure
- Shared package (common.svh):
  - csr_sched_state_t enum {IDLE, WAIT_HEAD, HOLD}.
  - `CSR_SCHED_DEPTH default constant.
  - The existing issue_execute_pack_t, execute_feedback_channel_t and commit_feedback_pack_t are reused.
- One sub-module, csr_operand_wakeup: combinational match and capture of rs1 against WAKEUP_PORTS channels, instanced per entry and once on the enqueue path.

## Test plan
- Ready op, ROB head already equal (rob_id=5), FIFO not full: enqueue at cycle 0 → push at cycle 1 with rob_id 5; state HOLD; busy 1.
- Pending operand: enqueue rs1_phy=12, src1_loaded=0 as head. Wakeup phy_id=12, value=0xDEAD_BEEF at cycle 3 → push at cycle 3 with src1_value 0xDEAD_BEEF and src1_loaded 1.
- Serialization: two ops, rob_id 7 and 8, head=7.
  - Op 7 pushes; op 8 is held while head stays 7, even when head later equals 8 in the same cycle the HOLD check is made.
  - Head advances to 8 → op 8 pushes one cycle later.
- Back-pressure and full: fill DEPTH=4 entries → in_ready 0. Hold issue_csr_fifo_full=1 at head match → no push. Release full → push next eligible cycle, and in_ready returns 1 the following cycle.
- Flush: enter HOLD with 2 entries queued, then assert commit flush with a simultaneous enqueue → next cycle empty, IDLE, busy 0, no push, enqueued op dropped.
- Reset: drive rst low during WAIT_HEAD with a matching head → no push, and in_ready 0 while rst is low. After release: empty, IDLE, in_ready 1.
